// File: rtl/can_sched_pkg.sv
// Shared types and constants for the CAN transmit scheduler.
package can_sched_pkg;

    localparam int COBID_W = 11;
    localparam int DLC_W   = 4;
    localparam int DATA_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_RETRY_FAIL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT    = 2'b10;

    // One frame as presented to the generator.
    typedef struct packed {
        logic [COBID_W-1:0] id;
        logic [DLC_W-1:0]   dlc;
        logic [DATA_W-1:0]  data;
    } frame_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    // Scan N positions starting at ptr; the first requester found wins.
    always_comb begin
        int            pos;
        logic [IW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Arbitrates frame requests onto one CAN frame generator with retry,
// per-attempt timeout and a per-transaction status response.
module can_tx_scheduler
    import can_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*COBID_W-1:0] req_id,
    input  logic [NREQ*DLC_W-1:0]   req_dlc,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic                    gen_start,
    output logic [COBID_W-1:0]      gen_id,
    output logic [DLC_W-1:0]        gen_dlc,
    output logic [DATA_W-1:0]       gen_data,
    input  logic                    gen_done,
    input  logic                    gen_lost,
    output logic                    resp_valid,
    output logic [2:0]              resp_src,
    output logic [1:0]              resp_status,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = ($clog2(GAP_CYC + 1) > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int TW = 20;

    sched_state_t      state, state_nxt;
    frame_t [NREQ-1:0] req_frame;
    frame_t            frame_q;
    logic [NREQ-1:0]   grant, req_ready_q;
    logic [IW-1:0]     grant_idx, rr_ptr, src_q;
    logic [TW-1:0]     timer_q;
    logic [GW-1:0]     gap_q;
    logic [RW-1:0]     retry_q;
    logic [1:0]        status_q, status_nxt;
    logic              grant_fire, retry_fire, resp_fire, send_entry;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_frame[g] = '{id:   req_id[COBID_W*g +: COBID_W],
                                dlc:  req_dlc[DLC_W*g +: DLC_W],
                                data: req_data[DATA_W*g +: DATA_W]};
    end

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection; done beats lost beats timeout when they coincide.
    always_comb begin
        state_nxt  = state;
        status_nxt = ST_OK;
        grant_fire = 1'b0;
        retry_fire = 1'b0;
        resp_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sched_en && |req_valid) begin
                    state_nxt  = SEND;
                    grant_fire = 1'b1;
                end
            end
            SEND: begin
                if (gen_done) begin
                    state_nxt  = RESP;
                    resp_fire  = 1'b1;
                    status_nxt = ST_OK;
                end else if (gen_lost) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        state_nxt  = RESP;
                        resp_fire  = 1'b1;
                        status_nxt = ST_RETRY_FAIL;
                    end else begin
                        state_nxt  = GAP;
                        retry_fire = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_nxt  = RESP;
                    resp_fire  = 1'b1;
                    status_nxt = ST_TIMEOUT;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) state_nxt = SEND;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign send_entry = (state_nxt == SEND) && (state != SEND);

    // Frame latch, counters, status and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            src_q       <= '0;
            rr_ptr      <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            status_q    <= ST_OK;
            req_ready_q <= '0;
        end else begin
            req_ready_q <= '0;
            if (grant_fire) begin
                frame_q     <= req_frame[grant_idx];
                src_q       <= grant_idx;
                retry_q     <= '0;
                req_ready_q <= grant;
            end
            if (retry_fire) retry_q <= retry_q + 1'b1;
            if (send_entry)         timer_q <= '0;
            else if (state == SEND) timer_q <= timer_q + 1'b1;
            if (state == GAP) gap_q <= gap_q + 1'b1;
            else              gap_q <= '0;
            if (resp_fire) status_q <= status_nxt;
            if (state == RESP)
                rr_ptr <= (src_q == IW'(NREQ - 1)) ? '0 : src_q + 1'b1;
        end
    end

    assign req_ready   = req_ready_q;
    assign gen_start   = (state == SEND);
    assign gen_id      = frame_q.id;
    assign gen_dlc     = frame_q.dlc;
    assign gen_data    = frame_q.data;
    assign resp_valid  = (state == RESP);
    assign resp_src    = (state == RESP) ? 3'(src_q) : 3'd0;
    assign resp_status = (state == RESP) ? status_q : 2'b00;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed table, hand sequences, random traffic.
module tb_can_tx_scheduler;

    localparam int NREQ = 4;
    localparam int MAXR = 3;
    localparam int GAPC = 8;
    localparam int TO   = 150;

    localparam int A_DONE = 0, A_LOST = 1, A_NONE = 2, A_BOTH = 3;
    localparam int S_OK = 0, S_RF = 1, S_TO = 2;

    logic              clk = 1'b0;
    logic              rst, sched_en, gen_done, gen_lost;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*11-1:0] req_id;
    logic [NREQ*4-1:0]  req_dlc;
    logic [NREQ*64-1:0] req_data;
    logic              gen_start, resp_valid, busy;
    logic [10:0]       gen_id;
    logic [3:0]        gen_dlc;
    logic [63:0]       gen_data;
    logic [2:0]        resp_src;
    logic [1:0]        resp_status;

    logic [10:0] rid   [NREQ];
    logic [3:0]  rdlc  [NREQ];
    logic [63:0] rdata [NREQ];

    int total = 0, bad = 0, mptr = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_id[11*g +: 11]  = rid[g];
        assign req_dlc[4*g +: 4]   = rdlc[g];
        assign req_data[64*g +: 64] = rdata[g];
    end

    can_tx_scheduler #(.NREQ(NREQ), .MAX_RETRY(MAXR), .GAP_CYC(GAPC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_dlc(req_dlc), .req_data(req_data),
        .gen_start(gen_start), .gen_id(gen_id), .gen_dlc(gen_dlc), .gen_data(gen_data),
        .gen_done(gen_done), .gen_lost(gen_lost),
        .resp_valid(resp_valid), .resp_src(resp_src), .resp_status(resp_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  set;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          np;
        int          plan[4];
        int          len;
        int          src;
        int          st;
        int          gaps;
    } row_t;

    row_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge. Requesters drop valid on ready.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (req_ready[k]) req_valid[k] = 1'b0;
    endtask

    task automatic load(input int k, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] d);
        rid[k] = id; rdlc[k] = dlc; rdata[k] = d;
    endtask

    function automatic row_t mk(input logic [3:0] set, input logic [10:0] id, input logic [3:0] dlc,
                                input logic [63:0] d, input int np, input int p0, input int p1,
                                input int p2, input int p3, input int len, input int src,
                                input int st, input int gaps);
        row_t r;
        r.set = set; r.id = id; r.dlc = dlc; r.data = d; r.np = np;
        r.plan[0] = p0; r.plan[1] = p1; r.plan[2] = p2; r.plan[3] = p3;
        r.len = len; r.src = src; r.st = st; r.gaps = gaps;
        return r;
    endfunction

    // Expected winner: first pending requester at or after the pointer.
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++)
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Expected outcome of an attempt plan: count losses against the retry budget.
    task automatic model(input int plan[4], input int np, output int st, output int gaps);
        int losses, act;
        losses = 0; gaps = 0; st = -1;
        for (int a = 0; a < 8 && st < 0; a++) begin
            act = (a < np) ? plan[a] : A_NONE;
            if (act == A_DONE || act == A_BOTH) st = S_OK;
            else if (act == A_LOST) begin
                if (losses == MAXR) st = S_RF;
                else begin losses++; gaps++; end
            end else st = S_TO;
        end
    endtask

    // Play the generator side of one transaction and observe the scheduler.
    task automatic run_txn(input int esrc, input int plan[4], input int np, input int len,
                           input int exp_wait, output int o_src, output int o_st, output int o_gaps);
        int cnt, a, act, ferr, hi, lo;
        logic [10:0] eid;
        logic [3:0]  edlc;
        logic [63:0] edata;
        logic        fin;
        eid = rid[esrc]; edlc = rdlc[esrc]; edata = rdata[esrc];
        o_src = -1; o_st = -1; o_gaps = 0; ferr = 0;
        cnt = 0;
        while (!gen_start && cnt < 40) begin tick(); cnt++; end
        if (exp_wait >= 0) check("grant_wait", cnt, exp_wait);
        if (!gen_start) begin
            check("grant_seen", 0, 1);
            return;
        end
        check("req_ready_onehot", int'(req_ready), 1 << esrc);
        // Inputs of the served requester may change freely now; the latch must hold.
        rid[esrc] = 11'($urandom); rdlc[esrc] = 4'($urandom); rdata[esrc] = {$urandom, $urandom};
        a = 0; fin = 1'b0;
        while (!fin && a < 8) begin
            act = (a < np) ? plan[a] : A_NONE;
            a++;
            hi = 1;
            if (gen_id !== eid || gen_dlc !== edlc || gen_data !== edata) ferr++;
            if (act == A_NONE) begin
                while (gen_start && hi < TO + 5) begin
                    tick();
                    if (gen_start) begin
                        hi++;
                        if (gen_id !== eid || gen_dlc !== edlc || gen_data !== edata) ferr++;
                    end
                end
                check("timeout_high_cycles", hi, TO);
            end else begin
                for (int i = 1; i < len; i++) begin
                    tick();
                    if (!gen_start) ferr++;
                    if (gen_id !== eid || gen_dlc !== edlc || gen_data !== edata) ferr++;
                end
                gen_done = (act == A_DONE || act == A_BOTH);
                gen_lost = (act == A_LOST || act == A_BOTH);
                tick();
                gen_done = 1'b0; gen_lost = 1'b0;
            end
            if (resp_valid) begin
                check("start_low_at_resp", int'(gen_start), 0);
                o_src = int'(resp_src); o_st = int'(resp_status); fin = 1'b1;
            end else begin
                lo = 0;
                while (!gen_start && !resp_valid && lo < GAPC + 10) begin
                    lo++;
                    gen_lost = (lo == 3);
                    gen_done = (lo == 5);
                    tick();
                    gen_lost = 1'b0; gen_done = 1'b0;
                end
                check("gap_low_cycles", lo, GAPC);
                o_gaps++;
                if (resp_valid) begin
                    o_src = int'(resp_src); o_st = int'(resp_status); fin = 1'b1;
                end else if (!gen_start) begin
                    check("gap_resume", 0, 1); fin = 1'b1;
                end else check("no_ready_on_retry", int'(req_ready), 0);
            end
        end
        check("frame_hold", ferr, 0);
        tick();
        check("resp_one_cycle", int'(resp_valid), 0);
        check("idle_after_resp", int'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int os, ost, og, cnt, esrc, est, egaps, np, len, k0;
        int p[4];

        rst = 1'b1; sched_en = 1'b1; gen_done = 1'b0; gen_lost = 1'b0; req_valid = '0;
        for (int k = 0; k < NREQ; k++) load(k, 11'h0, 4'h0, 64'h0);

        tbl[0]  = mk(4'hF, 11'h100, 4'd1, 64'h11, 1, A_DONE, 0, 0, 0, 4, 0, S_OK, 0);
        tbl[1]  = mk(4'h0, 11'h000, 4'd0, 64'h0, 1, A_DONE, 0, 0, 0, 4, 1, S_OK, 0);
        tbl[2]  = mk(4'h0, 11'h000, 4'd0, 64'h0, 1, A_DONE, 0, 0, 0, 4, 2, S_OK, 0);
        tbl[3]  = mk(4'h1, 11'h101, 4'd2, 64'h2222, 1, A_DONE, 0, 0, 0, 4, 3, S_OK, 0);
        tbl[4]  = mk(4'h0, 11'h000, 4'd0, 64'h0, 1, A_DONE, 0, 0, 0, 4, 0, S_OK, 0);
        tbl[5]  = mk(4'h4, 11'h602, 4'd8, 64'h4000_1000_0000_0000, 1, A_DONE, 0, 0, 0, 100, 2, S_OK, 0);
        tbl[6]  = mk(4'h2, 11'h181, 4'd3, 64'hA5, 3, A_LOST, A_LOST, A_DONE, 0, 6, 1, S_OK, 2);
        tbl[7]  = mk(4'h8, 11'h7FF, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4, A_LOST, A_LOST, A_LOST, A_LOST, 3, 3, S_RF, 3);
        tbl[8]  = mk(4'h1, 11'h000, 4'd0, 64'h0, 1, A_NONE, 0, 0, 0, 1, 0, S_TO, 0);
        tbl[9]  = mk(4'h2, 11'h555, 4'd9, 64'h0123_4567_89AB_CDEF, 1, A_BOTH, 0, 0, 0, 7, 1, S_OK, 0);
        tbl[10] = mk(4'h6, 11'h2AA, 4'd4, 64'hDEAD_BEEF, 1, A_DONE, 0, 0, 0, 3, 2, S_OK, 0);
        tbl[11] = mk(4'h0, 11'h000, 4'd0, 64'h0, 1, A_DONE, 0, 0, 0, 3, 1, S_OK, 0);

        // Reset state
        repeat (3) tick();
        check("rst_gen_start", int'(gen_start), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gen_fields", int'(gen_id != 0 || gen_dlc != 0 || gen_data != 0), 0);
        rst = 1'b0;

        // Directed table
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NREQ; k++)
                if (tbl[r].set[k]) begin
                    load(k, tbl[r].id, tbl[r].dlc, tbl[r].data);
                    req_valid[k] = 1'b1;
                end
            p = tbl[r].plan;
            run_txn(tbl[r].src, p, tbl[r].np, tbl[r].len, 1, os, ost, og);
            check($sformatf("row%0d_src", r), os, tbl[r].src);
            check($sformatf("row%0d_status", r), ost, tbl[r].st);
            check($sformatf("row%0d_gaps", r), og, tbl[r].gaps);
            mptr = (tbl[r].src + 1) % NREQ;
        end

        // Scheduler disabled: no grant; enable grants next edge; disabling mid-frame does not abort
        sched_en = 1'b0;
        load(1, 11'h3C1, 4'd5, 64'h0BAD_F00D_0000_0001);
        req_valid[1] = 1'b1;
        cnt = 0;
        repeat (100) begin
            tick();
            if (req_ready != 0 || gen_start || busy) cnt++;
        end
        check("disabled_no_grant", cnt, 0);
        sched_en = 1'b1;
        tick();
        check("enable_gen_start", int'(gen_start), 1);
        check("enable_req_ready", int'(req_ready), 4'b0010);
        sched_en = 1'b0;
        p[0] = A_LOST; p[1] = A_DONE; p[2] = 0; p[3] = 0;
        run_txn(1, p, 2, 5, 0, os, ost, og);
        check("en_src", os, 1);
        check("en_status", ost, S_OK);
        check("en_gaps", og, 1);
        sched_en = 1'b1;

        // Reset in the middle of a frame
        load(3, 11'h123, 4'd2, 64'h77);
        req_valid[3] = 1'b1;
        cnt = 0;
        while (!gen_start && cnt < 20) begin tick(); cnt++; end
        check("pre_reset_started", int'(gen_start), 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_outputs", int'(gen_start || busy || resp_valid || req_ready != 0 ||
                                     gen_id != 0 || gen_dlc != 0 || gen_data != 0 ||
                                     resp_src != 0 || resp_status != 0), 0);
        cnt = 0;
        repeat (2) begin tick(); if (resp_valid) cnt++; end
        rst = 1'b0;
        tick();
        if (resp_valid) cnt++;
        check("midrst_no_resp", cnt, 0);
        mptr = 0;

        // Random traffic against the transaction-level model
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
                    load(k, 11'($urandom), 4'($urandom), {$urandom, $urandom});
                    req_valid[k] = 1'b1;
                end else if (req_valid[k] && $urandom_range(0, 7) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            if (req_valid == 0) begin
                k0 = $urandom_range(0, NREQ - 1);
                load(k0, 11'($urandom), 4'($urandom), {$urandom, $urandom});
                req_valid[k0] = 1'b1;
            end
            np = $urandom_range(1, 4);
            for (int a = 0; a < 4; a++) begin
                int r;
                r = $urandom_range(0, 99);
                p[a] = (r < 45) ? A_LOST : (r < 85) ? A_DONE : (r < 94) ? A_BOTH : A_NONE;
            end
            len = $urandom_range(1, 12);
            esrc = pick(req_valid, mptr);
            model(p, np, est, egaps);
            run_txn(esrc, p, np, len, 1, os, ost, og);
            check($sformatf("rnd%0d_src", it), os, esrc);
            check($sformatf("rnd%0d_status", it), ost, est);
            check($sformatf("rnd%0d_gaps", it), og, egaps);
            mptr = (esrc + 1) % NREQ;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
